// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus for instr_encoder_loader.
// The slave modport is the encoder/loader side and the master modport is the requester/memory side.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        load_start;
    logic [31:0] start_addr;
    logic        im_we;
    logic        im_ready;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic [15:0] words_written;
    logic        err;

    modport master (
        output in_valid, fmt, rd, rs1, rs2, funct3, funct7b5, imm,
               load_start, start_addr, im_ready,
        input  in_ready, im_we, im_addr, im_wdata, words_written, err
    );

    modport slave (
        input  in_valid, fmt, rd, rs1, rs2, funct3, funct7b5, imm,
               load_start, start_addr, im_ready,
        output in_ready, im_we, im_addr, im_wdata, words_written, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32 instruction encoder feeding a 4-deep FIFO that streams words into instruction memory.
// Define ENC_IMM_CHECK_EN to reject requests whose immediate does not fit its encoding.
module instr_encoder_loader (
    input  logic                         clk,
    input  logic                         rst,
    instr_encoder_loader_if.slave        bus
);
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_L    = 3'd2;
    localparam logic [2:0] FMT_JALR = 3'd3;
    localparam logic [2:0] FMT_B    = 3'd4;
    localparam logic [2:0] FMT_S    = 3'd5;
    localparam logic [2:0] FMT_JAL  = 3'd6;
    localparam logic [2:0] FMT_BAD  = 3'd7;

    function automatic logic [31:0] encode(
        input logic [2:0]  fmt,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic        f7b5,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_R:    w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
            FMT_I: begin
                if (f3 == 3'b101) begin
                    w = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
                end
            end
            FMT_L:    w = {imm[11:0], rs1, f3, rd, 7'b0000011};
            FMT_JALR: w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            FMT_B:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            FMT_S:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            FMT_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default:  w = 32'd0;
        endcase
        return w;
    endfunction

`ifdef ENC_IMM_CHECK_EN
    // Sign-extension test: all bits from the sign position upward must agree.
    function automatic logic imm_ok(input logic [2:0] fmt, input logic [2:0] f3, input logic [31:0] imm);
        logic ok;
        case (fmt)
            FMT_I: begin
                if (f3 == 3'b101) begin
                    ok = (imm[31:5] == 27'd0);
                end else begin
                    ok = (imm[31:11] == 21'd0) || (imm[31:11] == 21'h1FFFFF);
                end
            end
            FMT_L, FMT_JALR, FMT_S:
                ok = (imm[31:11] == 21'd0) || (imm[31:11] == 21'h1FFFFF);
            FMT_B:
                ok = ((imm[31:12] == 20'd0) || (imm[31:12] == 20'hFFFFF)) && (imm[0] == 1'b0);
            FMT_JAL:
                ok = ((imm[31:20] == 12'd0) || (imm[31:20] == 12'hFFF)) && (imm[0] == 1'b0);
            default:
                ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    logic [31:0] mem_r [4];
    logic [1:0]  rd_ptr_r;
    logic [1:0]  wr_ptr_r;
    logic [2:0]  count_r;
    logic [31:0] im_addr_r;
    logic [15:0] words_written_r;
    logic        err_r;

    logic        accept_s;
    logic        reject_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] enc_word_s;

    // Outputs come straight from state; only in_ready also sees load_start.
    assign bus.in_ready      = (count_r != 3'd4) && !bus.load_start;
    assign bus.im_we         = (count_r != 3'd0);
    assign bus.im_wdata      = mem_r[rd_ptr_r];
    assign bus.im_addr       = im_addr_r;
    assign bus.words_written = words_written_r;
    assign bus.err           = err_r;

`ifndef ENC_IMM_CHECK_EN
    logic imm_unused_s;
    assign imm_unused_s = ^bus.imm[31:21];
`endif

    // Request acceptance, rejection and FIFO push/pop decisions.
    always_comb begin
        enc_word_s = encode(bus.fmt, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7b5, bus.imm);
        accept_s   = bus.in_valid && bus.in_ready;
`ifdef ENC_IMM_CHECK_EN
        reject_s   = accept_s && ((bus.fmt == FMT_BAD) || !imm_ok(bus.fmt, bus.funct3, bus.imm));
`else
        reject_s   = accept_s && (bus.fmt == FMT_BAD);
`endif
        push_s     = accept_s && !reject_s;
        pop_s      = bus.im_we && bus.im_ready && !bus.load_start;
    end

    // FIFO storage, write address/counter and error pulse; load_start flushes and rebases.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 32'd0;
            end
            rd_ptr_r        <= 2'd0;
            wr_ptr_r        <= 2'd0;
            count_r         <= 3'd0;
            im_addr_r       <= 32'd0;
            words_written_r <= 16'd0;
            err_r           <= 1'b0;
        end else if (bus.load_start) begin
            rd_ptr_r        <= 2'd0;
            wr_ptr_r        <= 2'd0;
            count_r         <= 3'd0;
            im_addr_r       <= bus.start_addr;
            words_written_r <= 16'd0;
            err_r           <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= enc_word_s;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r        <= rd_ptr_r + 2'd1;
                im_addr_r       <= im_addr_r + 32'd4;
                words_written_r <= words_written_r + 16'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
            err_r <= reject_s;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: stimulus pushes expected (addr, word) pairs,
// a negedge monitor pops and compares every memory write and every err pulse.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_loader_if bus();

    instr_encoder_loader dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int exp_err  = 0;
    int exp_ww   = 0;
    logic [31:0] next_addr = 32'd0;
    logic [63:0] sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a write handshake completes at the next edge; err pulses must be expected.
    always @(negedge clk) begin
        if (!rst && bus.im_we && bus.im_ready && !bus.load_start) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", bus.im_wdata, 32'hxxxxxxxx);
            end else begin
                logic [63:0] e;
                e = sbq.pop_front();
                chk("wr_addr", bus.im_addr, e[63:32]);
                chk("wr_data", bus.im_wdata, e[31:0]);
            end
        end
        if (!rst && bus.err) begin
            chk("err_expected", 32'(exp_err > 0), 32'd1);
            if (exp_err > 0) exp_err--;
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm, input logic [31:0] exp_word, input logic is_err);
        bit ok = 1'b0;
        bus.in_valid = 1'b1; bus.fmt = fmt; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7b5 = f7; bus.imm = imm;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (is_err) begin
            exp_err++;
        end else begin
            sbq.push_back({next_addr, exp_word});
            next_addr = next_addr + 32'd4;
            exp_ww++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr);
        bus.load_start = 1'b1;
        bus.start_addr = addr;
        sbq.delete();
        next_addr = addr;
        exp_ww = 0;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_done", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.fmt = 3'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.imm = 32'd0;
        bus.load_start = 1'b0; bus.start_addr = 32'd0; bus.im_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_im_we", 32'(bus.im_we), 32'd0);
        chk("rst_im_addr", bus.im_addr, 32'd0);
        chk("rst_im_wdata", bus.im_wdata, 32'd0);
        chk("rst_words", 32'(bus.words_written), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed encodings, streamed with memory always ready.
        bus.im_ready = 1'b1;
        do_load(32'h100);
        chk("load_addr", bus.im_addr, 32'h100);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h00500093, 1'b0);
        chk("first_latency_we", 32'(bus.im_we), 32'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 32'h402081B3, 1'b0);
        send(3'd1, 5'd5, 5'd5, 5'd0, 3'b101, 1'b1, 32'd3, 32'h4032D293, 1'b0);
        send(3'd5, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd4, 32'h0020A223, 1'b0);
        send(3'd6, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 32'h008000EF, 1'b0);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8, 32'h00208463, 1'b0);
        send(3'd2, 5'd2, 5'd1, 5'd0, 3'b010, 1'b0, 32'hFFFFFFFC, 32'hFFC0A103, 1'b0);
        send(3'd3, 5'd1, 5'd5, 5'd0, 3'b111, 1'b0, 32'h10, 32'h010280E7, 1'b0);
        send(3'd7, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1);
`ifdef ENC_IMM_CHECK_EN
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3, 32'd0, 1'b1);
`else
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3, 32'h00208163, 1'b0);
`endif
        wait_drain();
        chk("words_after_stream", 32'(bus.words_written), 32'(exp_ww));

        // Fill with memory stalled: fifth request must be held off, head must stay put.
        do_load(32'h100);
        bus.im_ready = 1'b0;
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 32'h00100093, 1'b0);
        send(3'd1, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 32'h00200113, 1'b0);
        send(3'd1, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3, 32'h00300193, 1'b0);
        send(3'd1, 5'd4, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4, 32'h00400213, 1'b0);
        bus.in_valid = 1'b1; bus.rd = 5'd5; bus.imm = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_wdata", bus.im_wdata, 32'h00100093);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("stall_words", 32'(bus.words_written), 32'd0);
        bus.im_ready = 1'b1;
        wait_drain();
        chk("full_words", 32'(bus.words_written), 32'd4);
        chk("full_addr", bus.im_addr, 32'h110);

        // Flush three queued words; the handshake during load_start must not count.
        do_load(32'h100);
        bus.im_ready = 1'b0;
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 32'h00100093, 1'b0);
        send(3'd1, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 32'h00200113, 1'b0);
        send(3'd1, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3, 32'h00300193, 1'b0);
        bus.im_ready = 1'b1;
        do_load(32'h2000);
        chk("flush_we", 32'(bus.im_we), 32'd0);
        chk("flush_addr", bus.im_addr, 32'h2000);
        chk("flush_words", 32'(bus.words_written), 32'd0);
        send(3'd1, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7, 32'h00700393, 1'b0);
        wait_drain();
        chk("post_flush_words", 32'(bus.words_written), 32'd1);
        chk("post_flush_addr", bus.im_addr, 32'h2004);

        // Reset mid-drain discards queued words.
        bus.im_ready = 1'b0;
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 32'h00100093, 1'b0);
        send(3'd1, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 32'h00200113, 1'b0);
        rst = 1'b1;
        bus.im_ready = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_we", 32'(bus.im_we), 32'd0);
        chk("midrst_words", 32'(bus.words_written), 32'd0);
        chk("midrst_addr", bus.im_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_words_hold", 32'(bus.words_written), 32'd0);

        chk("err_all_seen", 32'(exp_err), 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock); rst in 1 (reset); one clock, reset synchronous and active-high.
REQ-002 SHALL have ports: in_valid in 1 (request valid); in_ready out 1 (request accepted when both high).
REQ-003 SHALL have ports: fmt in 3 (0=R,1=I,2=L,3=JALR,4=B,5=S,6=JAL,7=invalid); rd, rs1, rs2 in 5 each; funct3 in 3; funct7b5 in 1; imm in 32 (signed byte offset/value).
REQ-004 SHALL have ports: load_start in 1 (set base address, flush); start_addr in 32 (base address).
REQ-005 SHALL have ports: im_we out 1 (write valid); im_ready in 1 (memory accepts write); im_addr out 32; im_wdata out 32 (encoded instruction).
REQ-006 SHALL have ports: words_written out 16 (completed writes); err out 1 (one-cycle rejection pulse).

Function
REQ-007 SHALL assign opcodes R=0110011, I=0010011, L=0000011, JALR=1100111, B=1100011, S=0100011, JAL=1101111.
REQ-008 R encoding SHALL be {0,funct7b5,00000, rs2, rs1, funct3, rd, op}.
REQ-009 I encoding: funct3=101 SHALL give {0,funct7b5,00000, imm[4:0], rs1, funct3, rd, op}; any other funct3 SHALL give {imm[11:0], rs1, funct3, rd, op}.
REQ-010 L encoding SHALL be {imm[11:0], rs1, funct3, rd, op}; JALR likewise, with funct3 forced to 000.
REQ-011 S encoding SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
REQ-012 B encoding SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
REQ-013 JAL encoding SHALL be {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-014 Encoded words SHALL enter a 4-entry FIFO; in_ready = FIFO not full AND load_start low; no bypass when full, even if a pop occurs that cycle.
REQ-015 Word accepted at edge t SHALL be stored at t; im_we high from cycle t+1 when FIFO was empty (one-cycle latency).
REQ-016 im_we SHALL equal FIFO non-empty; im_wdata SHALL be the head entry, held stable while im_we high and im_ready low.
REQ-017 On im_we AND im_ready: pop head, im_addr += 4 (mod 2^32), words_written += 1 (wraps 0xFFFF to 0).
REQ-018 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-019 fmt=7 SHALL be accepted (in_ready high), not enqueued, and err SHALL pulse high the next cycle.
REQ-020 load_start SHALL, at the next edge, empty the FIFO, set im_addr=start_addr, and clear words_written; any im_we/im_ready handshake that cycle SHALL not count.

Reset
REQ-021 rst at an edge SHALL give: FIFO empty, im_we=0, im_addr=0, im_wdata=0, words_written=0, err=0; in_ready=1 from the next cycle.
REQ-022 rst SHALL take priority over load_start, in_valid and im_ready; rst mid-drain SHALL discard queued words.

Configuration
REQ-023 Macro ENC_IMM_CHECK_EN defined: reject (accept, do not enqueue, pulse err) when imm is not signed 12-bit for I/L/JALR/S, has imm[31:5]!=0 for shifts, is not signed 13-bit or has imm[0]=1 for B, or is not signed 21-bit or has imm[0]=1 for JAL.
REQ-024 Macro ENC_IMM_CHECK_EN undefined: imm SHALL be silently truncated per REQ-009..013; err asserts only for fmt=7.

Verification
REQ-025 rst; load_start start_addr=0x100; fmt=1 rd=1 rs1=0 f3=0 imm=5 -> im_we next cycle, im_addr=0x100, im_wdata=0x00500093.
REQ-026 fmt=0 rd=3 rs1=1 rs2=2 f3=0 funct7b5=1 -> 0x402081B3; fmt=1 rd=5 rs1=5 f3=101 funct7b5=1 imm=3 -> 0x4032D293.
REQ-027 fmt=5 rs1=1 rs2=2 f3=010 imm=4 -> 0x0020A223; fmt=6 rd=1 imm=8 -> 0x008000EF.
REQ-028 im_ready=0, push 5 requests -> 4 accepted, in_ready=0; im_ready=1 -> four writes in order at 0x100..0x10C, words_written=4.
REQ-029 With ENC_IMM_CHECK_EN: fmt=4 imm=3 -> err pulse, nothing written; fmt=7 -> err pulse in both builds.
REQ-030 load_start with 3 queued words -> FIFO empty, im_addr=start_addr, words_written=0 next cycle.
